hazard_stall_ctrl: RTL

Pipeline stall controller for the 5-stage MIPS core. It decides each cycle whether the D-stage instruction must wait. When it must, PC and the F/D register hold and the D/E register loads a bubble, because its stall input clears it to zero. It covers two cases: register data hazards, judged by Tuse/Tnew against the E and M stage writers, and HI/LO structural hazards while the multi-cycle multiply/divide unit is busy. It also keeps a saturating stall-cycle performance counter.

---
 rtl/hazard_stall_ctrl_if.sv | 31 +++
 rtl/hazard_stall_ctrl.sv | 60 ++++++
 2 files changed

// File: rtl/hazard_stall_ctrl_if.sv
// Signal bundle between the pipeline stage registers and the hazard/stall controller.
// The master side drives the decoded stage fields. The slave side is the controller, which returns stall and MD status.
interface hazard_stall_ctrl_if;
    logic [4:0]  D_rs;
    logic [4:0]  D_rt;
    logic [1:0]  D_tuse_rs;
    logic [1:0]  D_tuse_rt;
    logic        D_is_md;
    logic [4:0]  E_a3;
    logic [1:0]  E_tnew;
    logic [4:0]  M_a3;
    logic [1:0]  M_tnew;
    logic        E_md_start;
    logic        E_md_is_div;
    logic        stall;
    logic        md_busy;
    logic [3:0]  md_count;
    logic [15:0] stall_cycles;

    modport master (
        output D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_is_md,
        output E_a3, E_tnew, M_a3, M_tnew, E_md_start, E_md_is_div,
        input  stall, md_busy, md_count, stall_cycles
    );

    modport slave (
        input  D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_is_md,
        input  E_a3, E_tnew, M_a3, M_tnew, E_md_start, E_md_is_div,
        output stall, md_busy, md_count, stall_cycles
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// D-stage stall decision for the 5-stage MIPS core: Tuse/Tnew data hazards plus HI/LO busy hazards.
// Also tracks multiply/divide busy time and keeps a saturating count of stalled cycles.
module hazard_stall_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    hazard_stall_ctrl_if.slave   hs
);
    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    logic [3:0]  md_count_q, md_count_d;
    logic [15:0] stall_cycles_q, stall_cycles_d;
    logic        stall_rs, stall_rt, stall_md, stall_int, md_busy_int;

    // A Tuse of 3 means the operand is not read. Register $0 never carries a real dependency.
    always_comb begin
        stall_rs = 1'b0;
        stall_rt = 1'b0;
        if (hs.D_tuse_rs != 2'd3 && hs.D_rs != 5'd0)
            stall_rs = (hs.D_rs == hs.E_a3 && hs.D_tuse_rs < hs.E_tnew) ||
                       (hs.D_rs == hs.M_a3 && hs.D_tuse_rs < hs.M_tnew);
        if (hs.D_tuse_rt != 2'd3 && hs.D_rt != 5'd0)
            stall_rt = (hs.D_rt == hs.E_a3 && hs.D_tuse_rt < hs.E_tnew) ||
                       (hs.D_rt == hs.M_a3 && hs.D_tuse_rt < hs.M_tnew);
    end

    assign md_busy_int = (md_count_q != 4'd0);
    assign stall_md    = hs.D_is_md && (hs.E_md_start || md_busy_int);
    assign stall_int   = !reset && (stall_rs || stall_rt || stall_md);

    // A new start reloads the counter even while the unit is still busy.
    always_comb begin
        md_count_d     = md_count_q;
        stall_cycles_d = stall_cycles_q;
        if (hs.E_md_start)
            md_count_d = hs.E_md_is_div ? DIV_LOAD : MULT_LOAD;
        else if (md_count_q != 4'd0)
            md_count_d = md_count_q - 4'd1;
        if (stall_int && stall_cycles_q != 16'hFFFF)
            stall_cycles_d = stall_cycles_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            md_count_q     <= 4'd0;
            stall_cycles_q <= 16'd0;
        end else begin
            md_count_q     <= md_count_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign hs.stall        = stall_int;
    assign hs.md_busy      = md_busy_int;
    assign hs.md_count     = md_count_q;
    assign hs.stall_cycles = stall_cycles_q;
endmodule
